// File: rtl/dekker_arb_pkg.sv
// dekker_arb_pkg: shared state encoding, client indices and defaults for the Dekker arbiter.
package dekker_arb_pkg;
  typedef enum logic [1:0] {FREE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2, GAP = 2'd3} state_e;
  localparam int C0 = 0;
  localparam int C1 = 1;
  localparam int GAP_CYCLES_DEF = 2;
  localparam int STARVE_LIMIT_DEF = 12;
  localparam int CNT_W_DEF = 8;
  localparam int WAIT_W_DEF = 4;
  function automatic int sat_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/dekker_wait_ctr.sv
// dekker_wait_ctr: saturating per-client wait counter with a sticky starvation flag.
module dekker_wait_ctr
  import dekker_arb_pkg::*;
#(
  parameter int WAIT_W = WAIT_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic waiting,
  input  logic clear,
  output logic starve
);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic starve_q, starve_d;
  always_comb begin
    wait_d = clear ? '0
           : (waiting && wait_q != WAIT_W'(sat_max(WAIT_W))) ? wait_q + WAIT_W'(1)
           : wait_q;
    starve_d = starve_q | (wait_d >= WAIT_W'(STARVE_LIMIT));
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wait_q <= '0;
      starve_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      starve_q <= starve_d;
    end
  assign starve = starve_q;
endmodule

// File: rtl/dekker_mutex_arbiter.sv
// dekker_mutex_arbiter: two-client four-phase req/gnt mutex; contention alternates via a turn
// register updated only on release, with an optional idle gap after each release.
module dekker_mutex_arbiter
  import dekker_arb_pkg::*;
#(
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int WAIT_W = WAIT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             turn,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic [1:0]       starve,
  output logic             mutex_err
);
  localparam int GAP_W = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(sat_max(CNT_W));
  state_e state_q, state_d;
  logic [1:0] gnt_q, gnt_d, grant_now;
  logic turn_q, turn_d, pick, mutex_err_q, mutex_err_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  // Lone requester wins outright; turn only breaks ties.
  assign pick = (req == 2'b11) ? turn_q : req[C1];
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    turn_d = turn_q;
    gap_d = gap_q;
    grant_now = 2'b00;
    case (state_q)
      FREE: if (req != 2'b00) begin
        state_d = pick ? OWN1 : OWN0;
        gnt_d = pick ? 2'b10 : 2'b01;
        grant_now = gnt_d;
      end
      OWN0: if (!req[C0]) begin
        gnt_d = 2'b00;
        turn_d = 1'b1;
        state_d = GAP_CYCLES > 0 ? GAP : FREE;
        gap_d = GAP_INIT;
      end
      OWN1: if (!req[C1]) begin
        gnt_d = 2'b00;
        turn_d = 1'b0;
        state_d = GAP_CYCLES > 0 ? GAP : FREE;
        gap_d = GAP_INIT;
      end
      GAP: begin
        gnt_d = 2'b00;
        state_d = gap_q == '0 ? FREE : GAP;
        gap_d = gap_q == '0 ? gap_q : gap_q - GAP_W'(1);
      end
    endcase
    cnt0_d = (grant_now[C0] && cnt0_q != CNT_SAT) ? cnt0_q + CNT_W'(1) : cnt0_q;
    cnt1_d = (grant_now[C1] && cnt1_q != CNT_SAT) ? cnt1_q + CNT_W'(1) : cnt1_q;
    mutex_err_d = mutex_err_q | (gnt_q[C0] & gnt_q[C1]);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= FREE;
      gnt_q <= 2'b00;
      turn_q <= 1'b0;
      gap_q <= '0;
      cnt0_q <= '0;
      cnt1_q <= '0;
      mutex_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      turn_q <= turn_d;
      gap_q <= gap_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      mutex_err_q <= mutex_err_d;
    end
  // The edge that grants also restarts that client's wait count.
  for (genvar i = 0; i < 2; i++) begin : g_wait
    dekker_wait_ctr #(.WAIT_W(WAIT_W), .STARVE_LIMIT(STARVE_LIMIT)) u_wait (
      .clock(clock),
      .reset(reset),
      .waiting(req[i] & ~gnt_q[i]),
      .clear(~req[i] | gnt_q[i] | grant_now[i]),
      .starve(starve[i])
    );
  end
  assign gnt = gnt_q;
  assign busy = state_q != FREE;
  assign turn = turn_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
  assign mutex_err = mutex_err_q;
endmodule

// File: tb/tb_dekker_mutex_arbiter.sv
// tb_dekker_mutex_arbiter: directed and random checks of the Dekker arbiter against a
// cycle-level reference model, plus a zero-gap instance for back-to-back handover.
module tb_dekker_mutex_arbiter;
  localparam int GAP = 2, LIM = 12, CW = 8, WW = 4;
  logic clock = 1'b0, reset = 1'b1;
  logic [1:0] req = 2'b00, req_z = 2'b00;
  logic [1:0] gnt, gnt_z, starve, starve_z;
  logic busy, busy_z, turn, turn_z, mutex_err, mutex_err_z;
  logic [CW-1:0] grant_cnt0, grant_cnt1, gc0_z, gc1_z;
  int errors = 0, checks = 0;
  typedef struct packed {
    logic [1:0] gnt;
    logic busy;
    logic turn;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] starve;
  } exp_t;
  exp_t sb[$];
  int m_owner, m_gap;
  int m_cnt[2], m_wait[2];
  logic m_turn;
  logic [1:0] m_starve;

  always #5 clock = ~clock;

  dekker_mutex_arbiter #(.GAP_CYCLES(GAP), .STARVE_LIMIT(LIM), .CNT_W(CW), .WAIT_W(WW)) u_dut (
    .clock(clock), .reset(reset), .req(req), .gnt(gnt), .busy(busy), .turn(turn),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .starve(starve), .mutex_err(mutex_err)
  );
  dekker_mutex_arbiter #(.GAP_CYCLES(0), .STARVE_LIMIT(LIM), .CNT_W(CW), .WAIT_W(WW)) u_dut_z (
    .clock(clock), .reset(reset), .req(req_z), .gnt(gnt_z), .busy(busy_z), .turn(turn_z),
    .grant_cnt0(gc0_z), .grant_cnt1(gc1_z), .starve(starve_z), .mutex_err(mutex_err_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] own_gnt(input int o);
    return o < 0 ? 2'b00 : (o == 1 ? 2'b10 : 2'b01);
  endfunction

  task automatic do_reset();
    req = 2'b00;
    req_z = 2'b00;
    reset = 1'b1;
    m_owner = -1;
    m_gap = 0;
    m_turn = 1'b0;
    m_cnt = '{0, 0};
    m_wait = '{0, 0};
    m_starve = 2'b00;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Drive one cycle, predict the main DUT's post-edge outputs, then compare them.
  task automatic cyc(input logic [1:0] r, input logic [1:0] rz);
    exp_t e, o;
    logic [1:0] g_old, g_new, gr;
    req = r;
    req_z = rz;
    g_old = own_gnt(m_owner);
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_turn = (m_owner == 0);
        m_owner = -1;
        m_gap = GAP;
      end
    end else if (m_gap > 0) m_gap--;
    else if (r != 2'b00) m_owner = (r == 2'b11) ? int'(m_turn) : int'(r[1]);
    g_new = own_gnt(m_owner);
    gr = g_new & ~g_old;
    for (int i = 0; i < 2; i++) begin
      if (gr[i] && m_cnt[i] < 255) m_cnt[i]++;
      if (gr[i] || !r[i] || g_old[i]) m_wait[i] = 0;
      else if (m_wait[i] < 15) m_wait[i]++;
      if (m_wait[i] >= LIM) m_starve[i] = 1'b1;
    end
    e.gnt = g_new;
    e.busy = (m_owner >= 0 || m_gap > 0);
    e.turn = m_turn;
    e.c0 = 8'(m_cnt[0]);
    e.c1 = 8'(m_cnt[1]);
    e.starve = m_starve;
    sb.push_back(e);
    @(posedge clock);
    #1;
    o = sb.pop_front();
    chk("gnt", gnt, o.gnt);
    chk("busy", busy, o.busy);
    chk("turn", turn, o.turn);
    chk("grant_cnt0", grant_cnt0, o.c0);
    chk("grant_cnt1", grant_cnt1, o.c1);
    chk("starve", starve, o.starve);
    chk("mutex_err", mutex_err, 0);
  endtask

  initial begin
    logic [1:0] r;
    int held[2], low[2];
    int last, onset, d;
    logic [1:0] pg;
    do_reset();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_turn", turn, 0);
    chk("rst_cnt0", grant_cnt0, 0);
    chk("rst_cnt1", grant_cnt1, 0);
    chk("rst_starve", starve, 0);
    chk("rst_mutex", mutex_err, 0);

    cyc(2'b00, 2'b00);
    cyc(2'b01, 2'b00);
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_busy", busy, 1);
    chk("t1_cnt0", grant_cnt0, 1);
    chk("t1_turn", turn, 0);
    repeat (3) cyc(2'b01, 2'b00);
    cyc(2'b00, 2'b00);
    chk("t1_rel_gnt", gnt, 2'b00);
    chk("t1_rel_turn", turn, 1);
    chk("t1_gap1", busy, 1);
    cyc(2'b00, 2'b00);
    chk("t1_gap2", busy, 1);
    cyc(2'b00, 2'b00);
    chk("t1_free", busy, 0);

    do_reset();
    cyc(2'b11, 2'b00);
    chk("t2_tie_gnt", gnt, 2'b01);
    cyc(2'b11, 2'b00);
    cyc(2'b10, 2'b00);
    chk("t2_rel_turn", turn, 1);
    repeat (2) cyc(2'b10, 2'b00);
    chk("t2_gap_gnt", gnt, 2'b00);
    cyc(2'b10, 2'b00);
    chk("t2_gnt1", gnt, 2'b10);
    cyc(2'b00, 2'b00);
    chk("t2_turn0", turn, 0);

    repeat (2) cyc(2'b00, 2'b00);
    cyc(2'b10, 2'b00);
    chk("t5_own1", gnt, 2'b10);
    reset = 1'b1;
    #1;
    chk("t5_async_gnt", gnt, 2'b00);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_cnt1", grant_cnt1, 0);
    chk("t5_async_turn", turn, 0);
    m_owner = -1;
    m_gap = 0;
    m_turn = 1'b0;
    m_cnt = '{0, 0};
    m_wait = '{0, 0};
    m_starve = 2'b00;
    @(posedge clock);
    #1 reset = 1'b0;
    cyc(2'b10, 2'b00);
    chk("t5_regrant", gnt, 2'b10);

    do_reset();
    r = 2'b11;
    held = '{0, 0};
    low = '{0, 0};
    last = -1;
    pg = 2'b00;
    for (int k = 0; k < 100; k++) begin
      cyc(r, 2'b00);
      if (gnt != 2'b00 && pg == 2'b00) begin
        if (last >= 0) chk("alternate", gnt, last == 0 ? 2'b10 : 2'b01);
        last = int'(gnt[1]);
      end
      pg = gnt;
      for (int i = 0; i < 2; i++) begin
        if (gnt[i]) begin
          held[i]++;
          if (held[i] == 3) begin
            r[i] = 1'b0;
            low[i] = 2;
            held[i] = 0;
          end
        end else if (low[i] > 0) begin
          low[i]--;
          if (low[i] == 0) r[i] = 1'b1;
        end
      end
    end
    d = int'(grant_cnt0) - int'(grant_cnt1);
    chk("cnt_balance", (d >= -1 && d <= 1), 1);
    chk("loop_starve", starve, 0);

    do_reset();
    cyc(2'b01, 2'b00);
    onset = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(2'b11, 2'b00);
      if (onset == 0 && starve[1]) onset = k;
    end
    chk("starve_onset", onset, LIM);
    repeat (4) cyc(2'b10, 2'b00);
    chk("starve_gnt1", gnt, 2'b10);
    chk("starve_sticky", starve, 2'b10);

    do_reset();
    cyc(2'b00, 2'b11);
    chk("z_tie", gnt_z, 2'b01);
    cyc(2'b00, 2'b10);
    chk("z_rel_gnt", gnt_z, 2'b00);
    chk("z_free", busy_z, 0);
    chk("z_turn", turn_z, 1);
    cyc(2'b00, 2'b10);
    chk("z_gnt1", gnt_z, 2'b10);
    chk("z_cnt1", gc1_z, 1);
    chk("z_cnt0", gc0_z, 1);
    chk("z_starve", starve_z, 0);

    for (int k = 0; k < 10000; k++) begin
      cyc(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      chk("z_overlap", gnt_z == 2'b11, 0);
    end
    chk("z_mutex", mutex_err_z, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
